mutex_client: RTL

- Hardware initiator for the Avalon-MM hardware mutex slave (two-word map: addr 0 = {owner[31:16], value[15:0]}, addr 1 = reset flag).
- Lets a non-CPU block, such as the Car2X TX framer, acquire and release a shared-buffer mutex with the same write-then-verify protocol software uses.
- Sits between the client logic and the interconnect as an Avalon-MM master with a fixed-zero read latency.

---
 rtl/mutex_pkg.sv | 21 ++
 rtl/mutex_client_backoff.sv | 29 ++
 rtl/mutex_client.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mutex_pkg.sv
// Shared definitions for the hardware-mutex client: register map, field slices, FSM states.
package mutex_pkg;

  localparam logic MUTEX_ADDR_STATE = 1'b0;
  localparam logic MUTEX_ADDR_RESET = 1'b1;

  localparam int OWNER_MSB = 31;
  localparam int OWNER_LSB = 16;
  localparam int VALUE_MSB = 15;
  localparam int VALUE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LOCK,
    ST_RD_CHECK,
    ST_BACKOFF,
    ST_HELD,
    ST_WR_REL
  } mutex_client_state_t;

endpackage

// File: rtl/mutex_client_backoff.sv
// Loadable down-counter with zero flag; spaces out lock attempts after a failed check.
module mutex_client_backoff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mutex_client.sv
// Avalon-MM initiator that acquires/releases a hardware mutex by write-then-verify.
// Optional retry limit: define MUTEX_CLIENT_RETRY_LIMIT_EN.
module mutex_client
  import mutex_pkg::*;
#(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int unsigned BACKOFF_CYCLES = 8,
  parameter int unsigned MAX_RETRIES    = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        acq_req,
  input  logic        rel_req,
  output logic        held,
  output logic        busy,
  output logic        acq_done,
  output logic        rel_done,
  output logic        acq_fail,
  output logic        av_address,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest
);

  localparam int CNT_W   = (BACKOFF_CYCLES > 0) ? $clog2(BACKOFF_CYCLES + 1) : 1;
  localparam int RW_RAW  = $clog2(MAX_RETRIES + 2);
  localparam int RETRY_W = (RW_RAW > 4) ? RW_RAW : 4;

  localparam logic [31:0] LOCK_WORD = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] FREE_WORD = {OWNER_ID, 16'h0000};

  mutex_client_state_t state_q, state_d;
  logic               held_q, held_d;
  logic               acq_done_q, acq_done_d;
  logic               rel_done_q, rel_done_d;
  logic               acq_fail_q, acq_fail_d;
  logic               addr_q, addr_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               bo_load, bo_dec, bo_zero;
  logic [CNT_W-1:0]   bo_cnt;
  logic               xfer_done;

  mutex_client_backoff #(.W(CNT_W)) u_backoff (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (bo_load),
    .load_val_i (CNT_W'(BACKOFF_CYCLES)),
    .dec_i      (bo_dec),
    .cnt_o      (bo_cnt),
    .zero_o     (bo_zero)
  );

  assign xfer_done = (rd_q || wr_q) && !av_waitrequest;

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    acq_done_d = 1'b0;
    rel_done_d = 1'b0;
    acq_fail_d = 1'b0;
    retry_d    = retry_q;
    bo_load    = 1'b0;
    bo_dec     = 1'b0;
    addr_d     = MUTEX_ADDR_STATE;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    case (state_q)
      ST_IDLE:     if (acq_req) state_d = ST_WR_LOCK;
      ST_WR_LOCK:  if (xfer_done) state_d = ST_RD_CHECK;
      ST_RD_CHECK: if (xfer_done) begin
        if (av_readdata == LOCK_WORD) begin
          state_d    = ST_HELD;
          held_d     = 1'b1;
          acq_done_d = 1'b1;
`ifdef MUTEX_CLIENT_RETRY_LIMIT_EN
          retry_d    = '0;
`endif
        end else begin
`ifdef MUTEX_CLIENT_RETRY_LIMIT_EN
          if (retry_q == RETRY_W'(MAX_RETRIES)) begin
            state_d    = ST_IDLE;
            acq_fail_d = 1'b1;
            retry_d    = '0;
          end else
`endif
          begin
            state_d = ST_BACKOFF;
            bo_load = 1'b1;
            if (retry_q != '1) retry_d = retry_q + 1'b1;
          end
        end
      end
      // Leaving on count==1 gives exactly BACKOFF_CYCLES idle bus cycles.
      ST_BACKOFF: begin
        bo_dec = 1'b1;
        if (bo_zero || bo_cnt == CNT_W'(1)) state_d = ST_WR_LOCK;
      end
      ST_HELD:     if (rel_req) state_d = ST_WR_REL;
      ST_WR_REL:   if (xfer_done) begin
        state_d    = ST_IDLE;
        held_d     = 1'b0;
        rel_done_d = 1'b1;
        retry_d    = '0;
      end
      default:     state_d = ST_IDLE;
    endcase
    // Strobes follow the next state, so they stay put while the slave stalls.
    case (state_d)
      ST_WR_LOCK:  begin wr_d = 1'b1; wdata_d = LOCK_WORD; end
      ST_RD_CHECK: rd_d = 1'b1;
      ST_WR_REL:   begin wr_d = 1'b1; wdata_d = FREE_WORD; end
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      held_q     <= 1'b0;
      acq_done_q <= 1'b0;
      rel_done_q <= 1'b0;
      acq_fail_q <= 1'b0;
      retry_q    <= '0;
      addr_q     <= MUTEX_ADDR_STATE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      acq_done_q <= acq_done_d;
      rel_done_q <= rel_done_d;
      acq_fail_q <= acq_fail_d;
      retry_q    <= retry_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
    end

  assign held         = held_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_HELD);
  assign acq_done     = acq_done_q;
  assign rel_done     = rel_done_q;
  assign acq_fail     = acq_fail_q;
  assign av_address   = addr_q;
  assign av_read      = rd_q;
  assign av_write     = wr_q;
  assign av_writedata = wdata_q;

endmodule
